// File: rtl/boid_vga_pkg.sv
// Shared bitmap geometry, coordinate widths and writer state encoding
// for the boid frame writer and its square stepper.
package boid_vga_pkg;

  localparam int VIDEO_WIDTH = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int PIXEL_COUNT = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH = 20;
  localparam int BOID_X_WIDTH = 10;
  localparam int BOID_Y_WIDTH = 9;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERASE = 3'd1;
  localparam logic [2:0] S_ACCEPT = 3'd2;
  localparam logic [2:0] S_DRAW = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef logic [PIXEL_ADDRESS_WIDTH-1:0] pix_addr_t;

  // x + 640*y without a multiplier
  function automatic pix_addr_t pix_addr(
    input logic [10:0] x,
    input logic [9:0] y
  );
    return (pix_addr_t'(y) << 9)
         + (pix_addr_t'(y) << 7)
         + pix_addr_t'(x);
  endfunction

endpackage

// File: rtl/boid_square_stepper.sv
// Walks one BOID_SIZE x BOID_SIZE square in raster order and
// produces the clipped bitmap address for the current offset.
module boid_square_stepper
  import boid_vga_pkg::*;
#(
  parameter int BOID_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BOID_X_WIDTH-1:0] base_x,
  input  logic [BOID_Y_WIDTH-1:0] base_y,
  output logic                    active,
  output logic                    running,
  output logic                    last,
  output logic                    in_range,
  output pix_addr_t               addr
);

  localparam logic [2:0] LAST = 3'(BOID_SIZE - 1);

  logic [2:0]  dx;
  logic [2:0]  dy;
  logic [10:0] x_sum;
  logic [9:0]  y_sum;

  // start yields offset (0,0) in the same cycle
  assign active = start | running;
  assign last = active && dx == LAST && dy == LAST;

  assign x_sum = {1'b0, base_x} + {8'd0, dx};
  assign y_sum = {1'b0, base_y} + {7'd0, dy};

  assign in_range = (x_sum < 11'(VIDEO_WIDTH))
                 && (y_sum < 10'(VIDEO_HEIGHT));
  assign addr = pix_addr(x_sum, y_sum);

  always_ff @(posedge clk) begin
    if (!reset) begin
      running <= 1'b0;
      dx <= '0;
      dy <= '0;
    end else if (active) begin
      if (last) begin
        running <= 1'b0;
        dx <= '0;
        dy <= '0;
      end else begin
        running <= 1'b1;
        if (dx == LAST) begin
          dx <= '0;
          dy <= dy + 3'd1;
        end else begin
          dx <= dx + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame erase/redraw of boid squares into the 1-bit bitmap.
// BOID_FULL_CLEAR_EN: erase sweeps the whole bitmap instead of the table.
module boid_frame_writer
  import boid_vga_pkg::*;
#(
  parameter int NUM_BOIDS = 16,
  parameter int BOID_SIZE = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           screenEnd,
  input  logic [BOID_X_WIDTH-1:0]        boid_x,
  input  logic [BOID_Y_WIDTH-1:0]        boid_y,
  input  logic                           boid_valid,
  output logic                           boid_ready,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] boid_write_address,
  output logic                           boid_write_data,
  output logic                           boid_write_en,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           frame_overrun
);

  localparam int IW = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BOIDS - 1);

  logic [2:0]              state;
  logic                    se_q;
  logic                    rise;
  logic [IW-1:0]           idx;
  logic [BOID_X_WIDTH-1:0] cur_x;
  logic [BOID_Y_WIDTH-1:0] cur_y;
  logic [BOID_X_WIDTH-1:0] base_x;
  logic [BOID_Y_WIDTH-1:0] base_y;
  logic                    step_start;
  logic                    step_en;
  logic                    step_run;
  logic                    step_last;
  logic                    step_in;
  pix_addr_t               step_addr;
  logic                    erase_step;
  logic                    erase_fin;
  logic                    take;

  assign rise = screenEnd & ~se_q;
  assign busy = state != S_IDLE;
  assign boid_ready = state == S_ACCEPT;
  assign frame_done = state == S_DONE;
  assign take = boid_ready & boid_valid;

`ifdef BOID_FULL_CLEAR_EN
  pix_addr_t clr;

  assign base_x = cur_x;
  assign base_y = cur_y;
  assign step_start = !step_run && state == S_DRAW;
  assign erase_step = 1'b0;
  assign erase_fin = clr == pix_addr_t'(PIXEL_COUNT - 1);

  always_ff @(posedge clk) begin
    if (!reset)
      clr <= '0;
    else if (state == S_ERASE)
      clr <= clr + 1'b1;
    else
      clr <= '0;
  end
`else
  logic [BOID_X_WIDTH-1:0] tab_x [NUM_BOIDS];
  logic [BOID_Y_WIDTH-1:0] tab_y [NUM_BOIDS];
  logic [NUM_BOIDS-1:0]    tab_v;

  // the table holds last frame's squares until ERASE has read them
  assign base_x = (state == S_ERASE) ? tab_x[idx] : cur_x;
  assign base_y = (state == S_ERASE) ? tab_y[idx] : cur_y;
  assign step_start = !step_run
    && ((state == S_ERASE && tab_v[idx]) || state == S_DRAW);
  assign erase_step = !tab_v[idx] || step_last;
  assign erase_fin = erase_step && idx == LAST_IDX;

  always_ff @(posedge clk) begin
    if (!reset)
      tab_v <= '0;
    else if (take)
      tab_v[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (take) begin
      tab_x[idx] <= boid_x;
      tab_y[idx] <= boid_y;
    end
  end
`endif

  boid_square_stepper #(
    .BOID_SIZE(BOID_SIZE)
  ) u_step (
    .clk(clk),
    .reset(reset),
    .start(step_start),
    .base_x(base_x),
    .base_y(base_y),
    .active(step_en),
    .running(step_run),
    .last(step_last),
    .in_range(step_in),
    .addr(step_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      idx <= '0;
      se_q <= 1'b0;
      cur_x <= '0;
      cur_y <= '0;
      frame_overrun <= 1'b0;
    end else begin
      se_q <= screenEnd;
      frame_overrun <= rise && state != S_IDLE;
      unique case (state)
        S_IDLE: begin
          if (rise) begin
            state <= S_ERASE;
            idx <= '0;
          end
        end
        S_ERASE: begin
          if (erase_fin) begin
            state <= S_ACCEPT;
            idx <= '0;
          end else if (erase_step) begin
            idx <= idx + 1'b1;
          end
        end
        S_ACCEPT: begin
          if (boid_valid) begin
            cur_x <= boid_x;
            cur_y <= boid_y;
            state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (step_last) begin
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              idx <= '0;
            end else begin
              state <= S_ACCEPT;
              idx <= idx + 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      boid_write_en <= 1'b0;
      boid_write_data <= 1'b0;
      boid_write_address <= '0;
    end else begin
      boid_write_en <= step_en && step_in;
      boid_write_data <= state == S_DRAW;
      boid_write_address <= step_addr;
`ifdef BOID_FULL_CLEAR_EN
      if (state == S_ERASE) begin
        boid_write_en <= 1'b1;
        boid_write_data <= 1'b0;
        boid_write_address <= clr;
      end
`endif
    end
  end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Randomized frame-level bench for boid_frame_writer against a
// pixel-list model of erase/draw (honours BOID_FULL_CLEAR_EN).
module tb_boid_frame_writer;
  import boid_vga_pkg::*;

  localparam int NB = 2;
  localparam int S = 2;
`ifdef BOID_FULL_CLEAR_EN
  localparam int WAIT_MAX = PIXEL_COUNT + 100;
`else
  localparam int WAIT_MAX = 100;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        screenEnd = 1'b0;
  logic [9:0]  boid_x = '0;
  logic [8:0]  boid_y = '0;
  logic        boid_valid = 1'b0;
  logic        boid_ready;
  logic [19:0] boid_write_address;
  logic        boid_write_data;
  logic        boid_write_en;
  logic        busy;
  logic        frame_done;
  logic        frame_overrun;

  always #5 clk = ~clk;

  boid_frame_writer #(
    .NUM_BOIDS(NB),
    .BOID_SIZE(S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .screenEnd(screenEnd),
    .boid_x(boid_x),
    .boid_y(boid_y),
    .boid_valid(boid_valid),
    .boid_ready(boid_ready),
    .boid_write_address(boid_write_address),
    .boid_write_data(boid_write_data),
    .boid_write_en(boid_write_en),
    .busy(busy),
    .frame_done(frame_done),
    .frame_overrun(frame_overrun)
  );

  int total = 0;
  int bad = 0;
  int got[$];
  int exp_q[$];
  int busy_cnt = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int px[NB];
  int py[NB];
  bit pv[NB];
  int bx[NB];
  int by[NB];
  int dly[NB];

  always @(negedge clk) begin
    if (boid_write_en)
      got.push_back(int'({11'd0, boid_write_data, boid_write_address}));
    if (busy) busy_cnt++;
    if (frame_done) done_cnt++;
    if (frame_overrun) ovr_cnt++;
  end

  task automatic chk(input string tag, input int g, input int e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, g, e);
    end
  endtask

  function automatic void add_sq(input int x, input int y, input int d);
    for (int j = 0; j < S; j++)
      for (int i = 0; i < S; i++)
        if (x + i < 640 && y + j < 480)
          exp_q.push_back(d * (1 << 20) + (y + j) * 640 + x + i);
  endfunction

  function automatic int rnd_x();
    if ($urandom_range(0, 3) == 0) return 638 + $urandom_range(0, 1);
    return $urandom_range(0, 639);
  endfunction

  function automatic int rnd_y();
    if ($urandom_range(0, 3) == 0) return 478 + $urandom_range(0, 1);
    return $urandom_range(0, 479);
  endfunction

  task automatic randomize_boids();
    for (int i = 0; i < NB; i++) begin
      bx[i] = rnd_x();
      by[i] = rnd_y();
      dly[i] = $urandom_range(0, 3);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!boid_ready && w < WAIT_MAX) begin
      @(negedge clk);
      w++;
    end
    if (!boid_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_frame(input int ovr_at);
    int eb;
    int w;
    int ib;
    int n;
    exp_q.delete();
    got.delete();
    busy_cnt = 0;
    done_cnt = 0;
    ovr_cnt = 0;
    eb = 1;
`ifdef BOID_FULL_CLEAR_EN
    for (int a = 0; a < PIXEL_COUNT; a++) exp_q.push_back(a);
    eb += PIXEL_COUNT;
`else
    for (int i = 0; i < NB; i++) begin
      if (pv[i]) begin
        add_sq(px[i], py[i], 0);
        eb += S * S;
      end else begin
        eb += 1;
      end
    end
`endif
    for (int i = 0; i < NB; i++) begin
      add_sq(bx[i], by[i], 1);
      eb += dly[i] + 1 + S * S;
    end
    screenEnd = 1'b1;
    @(negedge clk);
    screenEnd = 1'b0;
    for (int i = 0; i < NB; i++) begin
      wait_ready();
      ib = 0;
      for (int k = 0; k < dly[i]; k++) begin
        if (!boid_ready || frame_done || (k > 0 && boid_write_en)) ib++;
        @(negedge clk);
      end
      if (dly[i] > 0) chk("accept_idle", ib, 0);
      boid_x = 10'(bx[i]);
      boid_y = 9'(by[i]);
      boid_valid = 1'b1;
      @(negedge clk);
      boid_valid = 1'b0;
      if (ovr_at == i) begin
        screenEnd = 1'b1;
        @(negedge clk);
        screenEnd = 1'b0;
      end
    end
    w = 0;
    while (!frame_done && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", int'(frame_done), 1);
    repeat (3) @(negedge clk);
    chk("write_count", got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk("write", got[k], exp_q[k]);
    chk("busy_cycles", busy_cnt, eb);
    chk("done_pulses", done_cnt, 1);
    chk("overrun", ovr_cnt, (ovr_at >= 0) ? 1 : 0);
    for (int i = 0; i < NB; i++) begin
      px[i] = bx[i];
      py[i] = by[i];
      pv[i] = 1'b1;
    end
  endtask

  initial begin
    int c;
    for (int i = 0; i < NB; i++) begin
      pv[i] = 1'b0;
      dly[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(boid_ready), 0);
    chk("rst_we", int'(boid_write_en), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_ovr", int'(frame_overrun), 0);
    reset = 1'b1;
    @(negedge clk);

    bx[0] = 10; by[0] = 5; bx[1] = 0; by[1] = 0;
    do_frame(-1);
    if (got.size() >= 8) begin
`ifdef BOID_FULL_CLEAR_EN
      chk("t1_first", got[PIXEL_COUNT], (1 << 20) + 3210);
`else
      chk("t1_first", got[0], (1 << 20) + 3210);
      chk("t1_last", got[7], (1 << 20) + 641);
`endif
    end

    bx[0] = 20; by[0] = 5; bx[1] = 1; by[1] = 1;
    do_frame(-1);
`ifdef BOID_FULL_CLEAR_EN
    c = 0;
    foreach (got[k]) if (got[k] < (1 << 20)) c++;
    chk("clear_total", c, PIXEL_COUNT);
    if (got.size() >= PIXEL_COUNT) begin
      chk("clear_first", got[0], 0);
      chk("clear_last", got[PIXEL_COUNT-1], PIXEL_COUNT - 1);
    end
`else
    if (got.size() >= 8) chk("t2_erase0", got[0], 3210);

    bx[0] = 639; by[0] = 479; bx[1] = 639; by[1] = 479;
    do_frame(-1);
    c = 0;
    foreach (got[k]) if (got[k] == (1 << 20) + 307199) c++;
    chk("corner_writes", c, 2);

    randomize_boids();
    dly[0] = 10;
    do_frame(-1);

    randomize_boids();
    do_frame(0);

    for (int f = 0; f < 5; f++) begin
      randomize_boids();
      do_frame(($urandom_range(0, 2) == 0) ? NB - 1 : -1);
    end

    screenEnd = 1'b1;
    @(negedge clk);
    screenEnd = 1'b0;
    wait_ready();
    boid_x = 10'd100;
    boid_y = 9'd100;
    boid_valid = 1'b1;
    @(negedge clk);
    boid_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_we", int'(boid_write_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    reset = 1'b1;
    for (int i = 0; i < NB; i++) pv[i] = 1'b0;
    repeat (2) @(negedge clk);

    randomize_boids();
    do_frame(-1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
